// File: rtl/mx_pe_array_tile.sv
// ROWS x COLS MX-INT8 outer-product PE array with its own tile controller.
// Accumulates k_len operand beats into saturating PEs, then drains one row per beat.

module mx_pe #(
    parameter int ACC_W = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic signed [7:0] i_a,
    input  logic signed [7:0] i_b,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_sat
);
    logic signed [15:0] w_prod;
    logic [ACC_W:0]     w_sum;
    logic               w_clip;
    logic [ACC_W-1:0]   r_acc;

    assign w_prod = i_a * i_b;
    // One guard bit: overflow shows up as the top two sum bits disagreeing.
    assign w_sum  = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-15){w_prod[15]}}, w_prod};
    assign w_clip = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign o_sat  = i_en & w_clip;
    assign o_acc  = r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (w_clip)
                r_acc <= w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                r_acc <= w_sum[ACC_W-1:0];
        end
    end
endmodule

module mx_pe_array_tile #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int K_MAX = 32,
    parameter int ACC_W = 24,
    parameter int CNT_W = $clog2(K_MAX+1),
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      k_len_i,
    input  logic [7:0]            a_exp_i,
    input  logic [7:0]            b_exp_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ROWS*8-1:0]     a_data_i,
    input  logic [COLS*8-1:0]     b_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ROW_W-1:0]      out_row_o,
    output logic [COLS*ACC_W-1:0] out_data_o,
    output logic [7:0]            out_exp_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_k_len, r_k_cnt;
    logic [7:0]       r_a_exp, r_b_exp;
    logic [ROW_W-1:0] r_row;
    logic             r_done, r_ovf;

    logic                                 w_start, w_accept, w_drain_hs, w_last_row;
    logic [CNT_W-1:0]                     w_klen;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] w_acc;
    logic [ROWS-1:0][COLS-1:0]            w_sat;
    logic signed [9:0]                    w_esum;
    logic [7:0]                           w_exp;

    assign w_start    = (r_state == S_IDLE) && start_i;
    assign w_accept   = (r_state == S_ACCUM) && in_valid_i;
    assign w_drain_hs = (r_state == S_DRAIN) && out_ready_i;
    assign w_last_row = (r_row == ROW_W'(ROWS-1));
    assign w_klen     = (k_len_i > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len_i;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mx_pe #(.ACC_W(ACC_W)) u_pe (
                .i_clk (clk_i),
                .i_rst (rst_i),
                .i_clr (w_start),
                .i_en  (w_accept),
                .i_a   (a_data_i[8*r +: 8]),
                .i_b   (b_data_i[8*c +: 8]),
                .o_acc (w_acc[r][c]),
                .o_sat (w_sat[r][c])
            );
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_k_len <= '0;
            r_k_cnt <= '0;
            r_a_exp <= '0;
            r_b_exp <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_k_len <= w_klen;
                    r_k_cnt <= '0;
                    r_a_exp <= a_exp_i;
                    r_b_exp <= b_exp_i;
                    r_row   <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= (w_klen == '0) ? S_DRAIN : S_ACCUM;
                end
                S_ACCUM: if (w_accept) begin
                    r_k_cnt <= r_k_cnt + 1'b1;
                    if (|w_sat) r_ovf <= 1'b1;
                    if (r_k_cnt + 1'b1 == r_k_len) r_state <= S_DRAIN;
                end
                S_DRAIN: if (w_drain_hs) begin
                    if (w_last_row) begin
                        r_row   <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // 10-bit signed sum covers the full 0..383 range of a_exp + b_exp - 127 plus negatives.
    assign w_esum = $signed({2'b00, r_a_exp}) + $signed({2'b00, r_b_exp}) - 10'sd127;

    always_comb begin
        w_exp = 8'd0;
        if (r_a_exp == 8'hFF || r_b_exp == 8'hFF) w_exp = 8'hFF;
        else if (w_esum < 10'sd0)                 w_exp = 8'd0;
        else if (w_esum > 10'sd254)               w_exp = 8'd254;
        else                                      w_exp = w_esum[7:0];
    end

    assign in_ready_o  = (r_state == S_ACCUM);
    assign out_valid_o = (r_state == S_DRAIN);
    assign out_row_o   = r_row;
    assign out_data_o  = out_valid_o ? w_acc[r_row] : '0;
    assign out_exp_o   = out_valid_o ? w_exp : 8'd0;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign ovf_o       = r_ovf;
endmodule

// File: tb/tb_mx_pe_array_tile.sv
// Randomized bench for mx_pe_array_tile: a 24-bit and a 16-bit accumulator instance share
// stimulus and are compared against a per-beat saturating outer-product reference.

module tb_mx_pe_array_tile;
    localparam int ROWS = 8, COLS = 8, K_MAX = 32, CNT_W = 6;

    logic                 clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CNT_W-1:0]     k_len = '0;
    logic [7:0]           a_exp = '0, b_exp = '0;
    logic [ROWS*8-1:0]    a_data = '0;
    logic [COLS*8-1:0]    b_data = '0;

    logic                 in_ready, out_valid, busy, done, ovf;
    logic [2:0]           out_row;
    logic [COLS*24-1:0]   out_data;
    logic [7:0]           out_exp;
    logic                 in_ready16, out_valid16, busy16, done16, ovf16;
    logic [2:0]           out_row16;
    logic [COLS*16-1:0]   out_data16;
    logic [7:0]           out_exp16;

    mx_pe_array_tile #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .ACC_W(24)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len), .a_exp_i(a_exp), .b_exp_i(b_exp),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .a_data_i(a_data), .b_data_i(b_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_row_o(out_row), .out_data_o(out_data),
        .out_exp_o(out_exp), .busy_o(busy), .done_o(done), .ovf_o(ovf));

    mx_pe_array_tile #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX), .ACC_W(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len), .a_exp_i(a_exp), .b_exp_i(b_exp),
        .in_valid_i(in_valid), .in_ready_o(in_ready16), .a_data_i(a_data), .b_data_i(b_data),
        .out_valid_o(out_valid16), .out_ready_i(out_ready), .out_row_o(out_row16), .out_data_o(out_data16),
        .out_exp_o(out_exp16), .busy_o(busy16), .done_o(done16), .ovf_o(ovf16));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    longint m24[ROWS][COLS], m16[ROWS][COLS];
    bit     mo24, mo16;
    logic [COLS*24-1:0] cap24[ROWS];
    logic [COLS*16-1:0] cap16[ROWS];
    logic [7:0]         cap_exp[ROWS];
    int n_acc, n_rows, n_done, done_cyc, row_err, hold_err, valid_at_done, timeout;

    function automatic longint sat(longint v, int w);
        longint lim = longint'(1) << (w - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic int exp_model(int ea, int eb);
        int s;
        if (ea == 255 || eb == 255) return 255;
        s = ea + eb - 127;
        if (s < 0) return 0;
        if (s > 254) return 254;
        return s;
    endfunction

    function automatic logic [COLS*24-1:0] row24(int r);
        logic [COLS*24-1:0] v;
        for (int c = 0; c < COLS; c++) v[24*c +: 24] = m24[r][c][23:0];
        return v;
    endfunction

    function automatic logic [COLS*16-1:0] row16(int r);
        logic [COLS*16-1:0] v;
        for (int c = 0; c < COLS; c++) v[16*c +: 16] = m16[r][c][15:0];
        return v;
    endfunction

    // mode 0: a=fa, b=fb; mode 1: a[r]=r+1, b[c]=c+1; mode 2: random int8.
    task automatic drive_tile(input int k_req, input int ea, input int eb, input int mode,
                              input int fa, input int fb, input int gap_pct, input int stall_pct,
                              input bit poke);
        int cyc, ae[ROWS], be[COLS];
        bit pv_stall;
        logic [2:0] prow;
        logic [COLS*24-1:0] pdata;
        logic [7:0] pexp;
        longint v, s;
        for (int r = 0; r < ROWS; r++) begin
            cap24[r] = '0; cap16[r] = '0; cap_exp[r] = '0;
            for (int c = 0; c < COLS; c++) begin m24[r][c] = 0; m16[r][c] = 0; end
        end
        mo24 = 0; mo16 = 0; n_acc = 0; n_rows = 0; n_done = 0; done_cyc = 0;
        row_err = 0; hold_err = 0; valid_at_done = 0; timeout = 0; pv_stall = 0;
        @(negedge clk);
        start = 1'b1; k_len = k_req[CNT_W-1:0]; a_exp = ea[7:0]; b_exp = eb[7:0];
        cyc = 0;
        while (cyc < 400 && !(n_done > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke && in_ready && (cyc % 3 == 0)) begin
                start = 1'b1; k_len = 6'd5; a_exp = 8'd0; b_exp = 8'd0;
            end
            if (done) begin
                n_done++; done_cyc = cyc;
                if (out_valid) valid_at_done++;
            end
            if (out_valid) begin
                if (pv_stall && (out_row !== prow || out_data !== pdata || out_exp !== pexp)) hold_err++;
                cap24[out_row] = out_data; cap16[out_row] = out_data16; cap_exp[out_row] = out_exp;
                out_ready = ($urandom_range(99) >= stall_pct);
                if (out_ready) begin
                    if (int'(out_row) != n_rows) row_err++;
                    n_rows++;
                end
                pv_stall = !out_ready; prow = out_row; pdata = out_data; pexp = out_exp;
            end else begin
                out_ready = 1'($urandom_range(1));
                pv_stall = 0;
            end
            in_valid = ($urandom_range(99) >= gap_pct);
            for (int r = 0; r < ROWS; r++) begin
                ae[r] = (mode == 0) ? fa : (mode == 1) ? r + 1 : int'($urandom_range(255)) - 128;
                a_data[8*r +: 8] = ae[r][7:0];
            end
            for (int c = 0; c < COLS; c++) begin
                be[c] = (mode == 0) ? fb : (mode == 1) ? c + 1 : int'($urandom_range(255)) - 128;
                b_data[8*c +: 8] = be[c][7:0];
            end
            if (in_valid && in_ready) begin
                n_acc++;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) begin
                        v = m24[r][c] + longint'(ae[r] * be[c]); s = sat(v, 24);
                        if (s != v) mo24 = 1;
                        m24[r][c] = s;
                        v = m16[r][c] + longint'(ae[r] * be[c]); s = sat(v, 16);
                        if (s != v) mo16 = 1;
                        m16[r][c] = s;
                    end
            end
        end
        if (cyc >= 400) timeout = 1;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int nd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_row, out_data, out_exp, busy, done, ovf, busy16, ovf16} !== '0) begin
            errors++; $display("FAIL reset_outputs got busy=%b valid=%b want all 0", busy, out_valid);
        end
        rst = 1'b0;
        // abort mid-ACCUM
        @(negedge clk); start = 1'b1; k_len = 6'd10; a_exp = 8'd127; b_exp = 8'd127;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; a_data = {ROWS{8'd3}}; b_data = {COLS{8'd3}};
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_pre_accum got busy=%b ready=%b want 1 1", busy, in_ready);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_row, out_data, out_exp, busy, done, ovf} !== '0) begin
            errors++; $display("FAIL reset_mid_accum got busy=%b ready=%b want 0 0", busy, in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        nd = 0;
        repeat (4) begin @(negedge clk); if (done || busy) nd++; end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL reset_accum_idle got %0d busy/done cycles want 0", nd); end
        // abort mid-DRAIN while the output is stalled
        @(negedge clk); start = 1'b1; k_len = 6'd1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data[23:0] !== 24'd9) begin
            errors++; $display("FAIL reset_pre_drain got valid=%b d0=%0d want 1 9", out_valid, out_data[23:0]);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_row, out_data, out_exp, busy, done, ovf} !== '0) begin
            errors++; $display("FAIL reset_mid_drain got valid=%b data=%h want 0", out_valid, out_data);
        end
        rst = 1'b0;
        nd = 0;
        repeat (4) begin @(negedge clk); if (done || busy) nd++; end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL reset_drain_idle got %0d busy/done cycles want 0", nd); end
    endtask

    task automatic test_basic();
        logic [COLS*24-1:0] ev;
        int bad;
        drive_tile(1, 127, 127, 0, 1, 2, 0, 0, 0);
        checks++;
        if (timeout || n_acc != 1 || n_rows != 8 || row_err != 0) begin
            errors++; $display("FAIL basic_flow got acc=%0d rows=%0d rowerr=%0d to=%0d want 1 8 0 0",
                                n_acc, n_rows, row_err, timeout);
        end
        checks++;
        if (n_done != 1 || valid_at_done != 0 || done_cyc != 1 + ROWS + 1) begin
            errors++; $display("FAIL basic_done got n=%0d cyc=%0d vd=%0d want 1 %0d 0",
                                n_done, done_cyc, valid_at_done, 1 + ROWS + 1);
        end
        for (int c = 0; c < COLS; c++) ev[24*c +: 24] = 24'd2;
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (cap24[r] !== ev || cap_exp[r] !== 8'd127) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_data got %0d bad rows (row0=%h) want 0", bad, cap24[0]); end
        checks++;
        if (busy !== 1'b0 || out_exp !== 8'd0) begin
            errors++; $display("FAIL basic_idle got busy=%b exp=%0d want 0 0", busy, out_exp);
        end
    endtask

    task automatic test_stall();
        logic [COLS*24-1:0] ev;
        int bad;
        drive_tile(4, 127, 127, 1, 0, 0, 40, 40, 0);
        bad = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) ev[24*c +: 24] = 24'(4 * (r + 1) * (c + 1));
            if (cap24[r] !== ev) bad++;
        end
        checks++;
        if (bad != 0 || n_acc != 4 || timeout) begin
            errors++; $display("FAIL stall_data got bad=%0d acc=%0d to=%0d want 0 4 0", bad, n_acc, timeout);
        end
        checks++;
        if (hold_err != 0 || row_err != 0 || n_rows != 8 || n_done != 1) begin
            errors++; $display("FAIL stall_hold got hold=%0d rowerr=%0d rows=%0d done=%0d want 0 0 8 1",
                                hold_err, row_err, n_rows, n_done);
        end
    endtask

    task automatic test_sat();
        logic [COLS*16-1:0] ev;
        logic [COLS*24-1:0] ev24;
        int bad;
        drive_tile(3, 127, 127, 0, 127, 127, 0, 0, 0);
        for (int c = 0; c < COLS; c++) begin ev[16*c +: 16] = 16'h7FFF; ev24[24*c +: 24] = 24'd48387; end
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (cap16[r] !== ev || cap24[r] !== ev24) bad++;
        checks++;
        if (bad != 0 || ovf16 !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL sat_pos got bad=%0d ovf16=%b ovf24=%b want 0 1 0", bad, ovf16, ovf);
        end
        drive_tile(3, 127, 127, 0, -128, 127, 0, 0, 0);
        for (int c = 0; c < COLS; c++) ev[16*c +: 16] = 16'h8000;
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (cap16[r] !== ev) bad++;
        checks++;
        if (bad != 0 || ovf16 !== 1'b1) begin
            errors++; $display("FAIL sat_neg got bad=%0d ovf16=%b row0=%h want 0 1", bad, ovf16, cap16[0]);
        end
        drive_tile(2, 127, 127, 0, 1, 1, 0, 0, 0);
        for (int c = 0; c < COLS; c++) ev[16*c +: 16] = 16'd2;
        checks++;
        if (ovf16 !== 1'b0 || cap16[7] !== ev) begin
            errors++; $display("FAIL sat_clear got ovf16=%b row7=%h want 0 %h", ovf16, cap16[7], ev);
        end
    endtask

    task automatic test_exp();
        int ea[4] = '{250, 10, 255, 130};
        int eb[4] = '{200, 20, 7, 130};
        logic [7:0] want[4] = '{8'd254, 8'd0, 8'd255, 8'd133};
        for (int i = 0; i < 4; i++) begin
            drive_tile(0, ea[i], eb[i], 0, 0, 0, 0, 0, 0);
            checks++;
            if (cap_exp[0] !== want[i] || cap_exp[7] !== want[i]) begin
                errors++; $display("FAIL exp_%0d_%0d got %0d want %0d", ea[i], eb[i], cap_exp[0], want[i]);
            end
        end
    endtask

    task automatic test_klen();
        int bad;
        drive_tile(0, 127, 127, 1, 0, 0, 0, 0, 0);
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (cap24[r] !== '0) bad++;
        checks++;
        if (n_acc != 0 || bad != 0 || n_rows != 8 || done_cyc != ROWS + 1) begin
            errors++; $display("FAIL klen0 got acc=%0d bad=%0d rows=%0d cyc=%0d want 0 0 8 %0d",
                                n_acc, bad, n_rows, done_cyc, ROWS + 1);
        end
        drive_tile(40, 100, 120, 2, 0, 0, 0, 0, 1);
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (cap24[r] !== row24(r) || cap16[r] !== row16(r)) bad++;
        checks++;
        if (n_acc != K_MAX || bad != 0 || n_done != 1) begin
            errors++; $display("FAIL klen_clamp got acc=%0d bad=%0d done=%0d want %0d 0 1", n_acc, bad, n_done, K_MAX);
        end
        checks++;
        if (cap_exp[3] !== 8'(exp_model(100, 120))) begin
            errors++; $display("FAIL start_ignored_exp got %0d want %0d", cap_exp[3], exp_model(100, 120));
        end
    endtask

    task automatic test_random();
        int k, ea, eb, bad;
        for (int it = 0; it < 8; it++) begin
            k  = $urandom_range(40);
            ea = (it == 5) ? 255 : $urandom_range(254);
            eb = $urandom_range(255);
            drive_tile(k, ea, eb, 2, 0, 0, 30, 30, 0);
            bad = 0;
            for (int r = 0; r < ROWS; r++)
                if (cap24[r] !== row24(r) || cap16[r] !== row16(r) || cap_exp[r] !== 8'(exp_model(ea, eb))) bad++;
            checks++;
            if (bad != 0 || timeout) begin
                errors++; $display("FAIL rand_data_%0d got bad=%0d to=%0d row0=%h want 0 0 %h",
                                    it, bad, timeout, cap24[0], row24(0));
            end
            checks++;
            if (n_acc != ((k > K_MAX) ? K_MAX : k) || ovf16 !== mo16 || ovf !== mo24 ||
                hold_err != 0 || row_err != 0 || n_done != 1) begin
                errors++; $display("FAIL rand_ctrl_%0d got acc=%0d ovf=%b/%b hold=%0d rowerr=%0d done=%0d want %0d %b/%b 0 0 1",
                                    it, n_acc, ovf, ovf16, hold_err, row_err, n_done,
                                    (k > K_MAX) ? K_MAX : k, mo24, mo16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_sat();
        test_exp();
        test_klen();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
